// File: rtl/onchip_arb_pkg.sv
// Shared types and default sizes for the two-master on-chip RAM arbiter.
package onchip_arb_pkg;

    localparam int ARB_ADDR_W   = 18;
    localparam int ARB_DATA_W   = 32;
    localparam int ARB_HOLD_MAX = 4;

    // Which master currently owns the RAM port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    // One slot of the read-return pipe: is a read in flight, and for whom.
    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/onchip_arb_rdpipe.sv
// Read-return tag pipe: follows each accepted read through the RAM latency
// and raises the owning master's readdatavalid when the data appears.
module onchip_arb_rdpipe
    import onchip_arb_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic clear,
    input  logic load_valid,
    input  logic load_id,
    output logic valid0,
    output logic valid1
);

    rd_tag_t pipe_r [READ_LATENCY];

    // Shift tags toward the tail; clear drops every in-flight read.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0].valid <= load_valid;
            pipe_r[0].id    <= load_id;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign valid0 = pipe_r[READ_LATENCY-1].valid & ~pipe_r[READ_LATENCY-1].id;
    assign valid1 = pipe_r[READ_LATENCY-1].valid &  pipe_r[READ_LATENCY-1].id;

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Round-robin arbiter with bounded hold sharing one single-port RAM between
// two pipelined Avalon-MM masters. Grant and command mux are combinational so
// a command is accepted in the cycle it is presented.
module onchip_memory_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int HOLD_MAX     = ARB_HOLD_MAX,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic                  protocol_error
);

    localparam int         BE_W     = DATA_W / 8;
    localparam logic [3:0] HOLD_LIM = HOLD_MAX[3:0];

    owner_t      owner_r;
    owner_t      owner_nxt_s;
    logic [3:0]  hold_r;
    logic [3:0]  hold_nxt_s;
    logic        perr_r;
    logic        req0_s;
    logic        req1_s;
    logic        own_is1_s;
    logic        req_own_s;
    logic        req_oth_s;
    logic        gnt_v_s;
    logic        gnt_id_s;
    logic        write_s;
    logic        rd_accept_s;

    assign req0_s    = m0_read | m0_write;
    assign req1_s    = m1_read | m1_write;
    assign own_is1_s = (owner_r == OWN1);
    assign req_own_s = own_is1_s ? req1_s : req0_s;
    assign req_oth_s = own_is1_s ? req0_s : req1_s;

    // Grant decision and next owner/hold count.
    always_comb begin
        gnt_v_s     = 1'b0;
        gnt_id_s    = 1'b0;
        owner_nxt_s = owner_r;
        hold_nxt_s  = hold_r;
        case (owner_r)
            IDLE: begin
                if (req0_s) begin
                    gnt_v_s     = 1'b1;
                    gnt_id_s    = 1'b0;
                    owner_nxt_s = OWN0;
                    hold_nxt_s  = 4'd1;
                end else if (req1_s) begin
                    gnt_v_s     = 1'b1;
                    gnt_id_s    = 1'b1;
                    owner_nxt_s = OWN1;
                    hold_nxt_s  = 4'd1;
                end else begin
                    owner_nxt_s = IDLE;
                    hold_nxt_s  = 4'd0;
                end
            end
            OWN0, OWN1: begin
                if (req_own_s && (!req_oth_s || (hold_r < HOLD_LIM))) begin
                    // Owner keeps the port; count saturates at the limit.
                    gnt_v_s     = 1'b1;
                    gnt_id_s    = own_is1_s;
                    hold_nxt_s  = (hold_r >= HOLD_LIM) ? HOLD_LIM : hold_r + 4'd1;
                end else if (req_oth_s) begin
                    // Hold exhausted or owner went quiet: hand over, no bubble.
                    gnt_v_s     = 1'b1;
                    gnt_id_s    = ~own_is1_s;
                    owner_nxt_s = own_is1_s ? OWN0 : OWN1;
                    hold_nxt_s  = 4'd1;
                end else begin
                    owner_nxt_s = IDLE;
                    hold_nxt_s  = 4'd0;
                end
            end
            default: begin
                owner_nxt_s = IDLE;
                hold_nxt_s  = 4'd0;
            end
        endcase
    end

    // Route the granted master's command to the RAM; zeros when idle.
    always_comb begin
        mem_address    = {ADDR_W{1'b0}};
        mem_byteenable = {BE_W{1'b0}};
        mem_writedata  = {DATA_W{1'b0}};
        write_s        = 1'b0;
        if (gnt_v_s) begin
            if (gnt_id_s) begin
                mem_address    = m1_address;
                mem_byteenable = m1_byteenable;
                mem_writedata  = m1_writedata;
                write_s        = m1_write;
            end else begin
                mem_address    = m0_address;
                mem_byteenable = m0_byteenable;
                mem_writedata  = m0_writedata;
                write_s        = m0_write;
            end
        end else begin
            write_s = 1'b0;
        end
    end

    // Read+write together counts as a write, so only pure reads enter the pipe.
    assign rd_accept_s    = gnt_v_s & ~write_s;
    assign mem_write      = write_s;
    assign mem_chipselect = gnt_v_s;
    assign mem_clken      = 1'b1;
    assign m0_waitrequest = req0_s & ~(gnt_v_s & ~gnt_id_s);
    assign m1_waitrequest = req1_s & ~(gnt_v_s &  gnt_id_s);
    assign m0_readdata    = mem_readdata;
    assign m1_readdata    = mem_readdata;
    assign protocol_error = perr_r;

    // Owner state, hold count and sticky protocol error.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r <= IDLE;
            hold_r  <= 4'd0;
            perr_r  <= 1'b0;
        end else begin
            owner_r <= owner_nxt_s;
            hold_r  <= hold_nxt_s;
            perr_r  <= perr_r | (m0_read & m0_write) | (m1_read & m1_write);
        end
    end

    onchip_arb_rdpipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_rdpipe (
        .clk        (clk),
        .clear      (reset),
        .load_valid (rd_accept_s),
        .load_id    (gnt_id_s),
        .valid0     (m0_readdatavalid),
        .valid1     (m1_readdatavalid)
    );

endmodule
